// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a byte stream.
// Bytes arrive over a valid/ready handshake, are packed little-endian into
// 32-bit words and written one word per write cycle. The CPU is held in reset
// while a load is running. An XOR checksum of the written words is kept.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for i_start; CPU released
// RECV   | collecting bytes of the current word; CPU held in reset
// WRITE  | single cycle driving the packed word to instruction memory
// DONE   | one-cycle completion pulse, then back to IDLE
module imem_loader #(
    parameter int ADDR_W    = 32,
    parameter int MAX_WORDS = 256,
    parameter int CNT_W     = 9
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [CNT_W-1:0]  i_num_words,
    input  logic              i_abort,
    input  logic              i_valid,
    input  logic [7:0]        i_byte,
    output logic              o_ready,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [31:0]       o_wdata,
    output logic              o_cpu_rstn,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_aborted,
    output logic [31:0]       o_csum
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

    state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       buf_q, buf_d;
    logic [31:0]       csum_q, csum_d;
    logic              aborted_q, aborted_d;

    logic              start_ok;
    logic              byte_fire;
    logic              last_byte;
    logic              loading;
    logic [CNT_W-1:0]  num_clamped;
    logic [ADDR_W-1:0] base_aligned;

    // The two low address bits are dropped so every load is word aligned.
    logic unused_base_lsbs;
    assign unused_base_lsbs = ^i_base_addr[1:0];

    // Handshake and request qualification shared by the FSM and datapath.
    always_comb begin
        loading      = (state_q == ST_RECV) || (state_q == ST_WRITE);
        start_ok     = (state_q == ST_IDLE) && i_start;
        byte_fire    = (state_q == ST_RECV) && i_valid && !i_abort;
        last_byte    = byte_fire && (byte_idx_q == 2'd3);
        num_clamped  = (i_num_words > MAX_CNT) ? MAX_CNT : i_num_words;
        base_aligned = {i_base_addr[ADDR_W-1:2], 2'b00};
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; abort overrides the normal transitions.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = (num_clamped == '0) ? ST_DONE : ST_RECV;
                end
            end
            ST_RECV: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                end else if (last_byte) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RECV;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM output decode; o_ready drops combinationally while abort is high
    // so a byte offered alongside the abort stays with the source.
    always_comb begin
        o_ready    = (state_q == ST_RECV) && !i_abort;
        o_we       = (state_q == ST_WRITE);
        o_busy     = loading;
        o_cpu_rstn = !loading;
        o_done     = (state_q == ST_DONE);
        o_aborted  = aborted_q;
        o_addr     = addr_q;
        o_wdata    = buf_q;
        o_csum     = csum_q;
    end

    // Datapath next values: latch on start, pack bytes, retire a word on write.
    always_comb begin
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        byte_idx_d = byte_idx_q;
        buf_d      = buf_q;
        csum_d     = csum_q;
        aborted_d  = loading && i_abort;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    addr_d     = base_aligned;
                    cnt_d      = num_clamped;
                    csum_d     = '0;
                    byte_idx_d = '0;
                end
            end
            ST_RECV: begin
                if (i_abort) begin
                    byte_idx_d = '0;
                end else if (byte_fire) begin
                    buf_d[{byte_idx_q, 3'b000} +: 8] = i_byte;
                    byte_idx_d = byte_idx_q + 2'd1;
                end
            end
            ST_WRITE: begin
                csum_d = csum_q ^ buf_q;
                addr_d = addr_q + WORD_STEP;
                cnt_d  = cnt_q - CNT_W'(1);
            end
            default: begin
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            addr_q     <= '0;
            cnt_q      <= '0;
            byte_idx_q <= '0;
            buf_q      <= '0;
            csum_q     <= '0;
            aborted_q  <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            byte_idx_q <= byte_idx_d;
            buf_q      <= buf_d;
            csum_q     <= csum_d;
            aborted_q  <= aborted_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader.
module tb_imem_loader;

    localparam int ADDR_W    = 32;
    localparam int MAX_WORDS = 256;
    localparam int CNT_W     = 9;

    logic              i_clk = 1'b0;
    logic              i_rstn = 1'b0;
    logic              i_start = 1'b0;
    logic [ADDR_W-1:0] i_base_addr = '0;
    logic [CNT_W-1:0]  i_num_words = '0;
    logic              i_abort = 1'b0;
    logic              i_valid = 1'b0;
    logic [7:0]        i_byte = '0;
    logic              o_ready;
    logic              o_we;
    logic [ADDR_W-1:0] o_addr;
    logic [31:0]       o_wdata;
    logic              o_cpu_rstn;
    logic              o_busy;
    logic              o_done;
    logic              o_aborted;
    logic [31:0]       o_csum;

    imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_num_words(i_num_words), .i_abort(i_abort), .i_valid(i_valid), .i_byte(i_byte),
        .o_ready(o_ready), .o_we(o_we), .o_addr(o_addr), .o_wdata(o_wdata),
        .o_cpu_rstn(o_cpu_rstn), .o_busy(o_busy), .o_done(o_done),
        .o_aborted(o_aborted), .o_csum(o_csum)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_tmo = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int done_cnt = 0;
    int abort_cnt = 0;
    int overlap_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Write/pulse monitor, sampled on the falling edge.
    always @(negedge i_clk) begin
        if (o_we) begin
            wr_addr.push_back(o_addr);
            wr_data.push_back(o_wdata);
            if (o_ready) overlap_cnt++;
        end
        if (o_done) done_cnt++;
        if (o_aborted) abort_cnt++;
    end

    // Stimulus steps land 1ns after the falling edge, after the monitor.
    task automatic tick();
        @(negedge i_clk);
        #1;
    endtask

    task automatic start(input logic [31:0] base, input int num);
        i_base_addr = base;
        i_num_words = CNT_W'(num);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit acc;
        bit ok;
        ok = 1'b0;
        i_valid = 1'b1;
        i_byte = b;
        for (int k = 0; k < 16; k++) begin
            acc = o_ready;
            tick();
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        i_valid = 1'b0;
        if (!ok) n_tmo++;
    endtask

    task automatic send_word(input logic [31:0] w, input bit stall);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
            if (stall) tick();
        end
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (o_done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic run_normal(input bit stall, input string tag);
        int w0;
        int d0;
        bit seen;
        w0 = wr_addr.size();
        d0 = done_cnt;
        start(32'h0000_0010, 2);
        chk({tag, "_cpu_rstn_low"}, 32'(o_cpu_rstn), 32'd0);
        chk({tag, "_busy"}, 32'(o_busy), 32'd1);
        send_word(32'h0000_0013, stall);
        send_word(32'h0010_0093, stall);
        wait_done(seen);
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_csum"}, o_csum, 32'h0010_0080);
        chk({tag, "_cpu_rstn_done"}, 32'(o_cpu_rstn), 32'd1);
        tick();
        chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_nwrites"}, 32'(wr_addr.size() - w0), 32'd2);
        if (wr_addr.size() >= w0 + 2) begin
            chk({tag, "_addr0"}, wr_addr[w0], 32'h0000_0010);
            chk({tag, "_data0"}, wr_data[w0], 32'h0000_0013);
            chk({tag, "_addr1"}, wr_addr[w0+1], 32'h0000_0014);
            chk({tag, "_data1"}, wr_data[w0+1], 32'h0010_0093);
        end
        chk({tag, "_csum_hold"}, o_csum, 32'h0010_0080);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int d0;
        int a0;
        int bad_a;
        int bad_d;
        bit seen;
        logic [31:0] w;
        logic [31:0] exp_csum;

        // Reset values
        repeat (3) tick();
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_we", 32'(o_we), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_aborted", 32'(o_aborted), 32'd0);
        chk("rst_addr", o_addr, 32'd0);
        chk("rst_wdata", o_wdata, 32'd0);
        chk("rst_csum", o_csum, 32'd0);
        chk("rst_cpu_rstn", 32'(o_cpu_rstn), 32'd1);
        i_rstn = 1'b1;
        tick();

        run_normal(1'b0, "norm");
        run_normal(1'b1, "stall");
        chk("no_we_with_ready", 32'(overlap_cnt), 32'd0);

        // Zero-word load: straight to DONE, checksum cleared
        w0 = wr_addr.size();
        start(32'h0000_0050, 0);
        chk("zero_done", 32'(o_done), 32'd1);
        chk("zero_csum", o_csum, 32'd0);
        chk("zero_busy", 32'(o_busy), 32'd0);
        tick();
        chk("zero_nwrites", 32'(wr_addr.size() - w0), 32'd0);

        // Oversized request clamped to 256 words
        w0 = wr_addr.size();
        d0 = done_cnt;
        exp_csum = '0;
        start(32'h0000_1000, 300);
        for (int i = 0; i < 300; i++) begin
            for (int j = 0; j < 4; j++) w[8*j +: 8] = 8'((4*i + j) * 7 + 3);
            if (i < MAX_WORDS) begin
                exp_csum = exp_csum ^ w;
                send_word(w, 1'b0);
            end
        end
        wait_done(seen);
        chk("clamp_done_seen", 32'(seen), 32'd1);
        chk("clamp_csum", o_csum, exp_csum);
        tick();
        chk("clamp_nwrites", 32'(wr_addr.size() - w0), 32'd256);
        chk("clamp_done_pulses", 32'(done_cnt - d0), 32'd1);
        if (wr_addr.size() >= w0 + 256) begin
            chk("clamp_first_addr", wr_addr[w0], 32'h0000_1000);
            chk("clamp_last_addr", wr_addr[w0+255], 32'h0000_13FC);
            bad_a = 0;
            bad_d = 0;
            for (int i = 0; i < 256; i++) begin
                for (int j = 0; j < 4; j++) w[8*j +: 8] = 8'((4*i + j) * 7 + 3);
                if (wr_addr[w0+i] !== 32'h0000_1000 + 32'(4*i)) bad_a++;
                if (wr_data[w0+i] !== w) bad_d++;
            end
            chk("clamp_addr_errs", 32'(bad_a), 32'd0);
            chk("clamp_data_errs", 32'(bad_d), 32'd0);
        end

        // Unaligned base rounds down
        w0 = wr_addr.size();
        start(32'h0000_0003, 1);
        send_word(32'hDDCC_BBAA, 1'b0);
        wait_done(seen);
        chk("unal_done_seen", 32'(seen), 32'd1);
        tick();
        chk("unal_nwrites", 32'(wr_addr.size() - w0), 32'd1);
        if (wr_addr.size() > w0) begin
            chk("unal_addr", wr_addr[w0], 32'h0000_0000);
            chk("unal_data", wr_data[w0], 32'hDDCC_BBAA);
        end
        chk("unal_csum", o_csum, 32'hDDCC_BBAA);

        // Abort in RECV after 6 bytes of a 4-word load
        w0 = wr_addr.size();
        d0 = done_cnt;
        a0 = abort_cnt;
        start(32'h0000_0020, 4);
        send_word(32'h1413_1211, 1'b0);
        send_byte(8'h15);
        send_byte(8'h16);
        i_valid = 1'b1;
        i_byte = 8'h77;
        i_abort = 1'b1;
        #1;
        chk("abort_ready_forced", 32'(o_ready), 32'd0);
        tick();
        i_abort = 1'b0;
        i_valid = 1'b0;
        chk("abort_pulse", 32'(o_aborted), 32'd1);
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_cpu_rstn", 32'(o_cpu_rstn), 32'd1);
        tick();
        chk("abort_pulse_end", 32'(o_aborted), 32'd0);
        chk("abort_nwrites", 32'(wr_addr.size() - w0), 32'd1);
        chk("abort_pulses", 32'(abort_cnt - a0), 32'd1);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        if (wr_addr.size() > w0) begin
            chk("abort_addr", wr_addr[w0], 32'h0000_0020);
            chk("abort_data", wr_data[w0], 32'h1413_1211);
        end

        // Next load after abort must start from byte lane 0
        w0 = wr_addr.size();
        start(32'h0000_0030, 1);
        send_word(32'h0403_0201, 1'b0);
        wait_done(seen);
        chk("post_abort_done", 32'(seen), 32'd1);
        chk("post_abort_csum", o_csum, 32'h0403_0201);
        tick();
        if (wr_addr.size() > w0) chk("post_abort_data", wr_data[w0], 32'h0403_0201);
        else chk("post_abort_nwrites", 32'(wr_addr.size() - w0), 32'd1);

        // Abort sampled during WRITE: that write completes
        w0 = wr_addr.size();
        d0 = done_cnt;
        start(32'h0000_0040, 2);
        send_word(32'hD4C3_B2A1, 1'b0);
        chk("abw_in_write", 32'(o_we), 32'd1);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("abw_pulse", 32'(o_aborted), 32'd1);
        chk("abw_busy", 32'(o_busy), 32'd0);
        chk("abw_csum", o_csum, 32'hD4C3_B2A1);
        tick();
        chk("abw_nwrites", 32'(wr_addr.size() - w0), 32'd1);
        chk("abw_no_done", 32'(done_cnt - d0), 32'd0);
        if (wr_addr.size() > w0) chk("abw_addr", wr_addr[w0], 32'h0000_0040);

        // Start pulse while busy is ignored
        w0 = wr_addr.size();
        start(32'h0000_0080, 1);
        send_byte(8'h5A);
        send_byte(8'h6B);
        i_base_addr = 32'h0000_0200;
        i_num_words = CNT_W'(5);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("busy_start_addr", o_addr, 32'h0000_0080);
        chk("busy_start_busy", 32'(o_busy), 32'd1);
        send_byte(8'h7C);
        send_byte(8'h8D);
        wait_done(seen);
        chk("busy_start_done", 32'(seen), 32'd1);
        chk("busy_start_csum", o_csum, 32'h8D7C_6B5A);
        tick();
        chk("busy_start_nwrites", 32'(wr_addr.size() - w0), 32'd1);
        if (wr_addr.size() > w0) chk("busy_start_wdata", wr_data[w0], 32'h8D7C_6B5A);

        // Reset mid-load
        start(32'h0000_0060, 2);
        send_byte(8'hEE);
        send_byte(8'hFF);
        i_rstn = 1'b0;
        tick();
        i_rstn = 1'b1;
        chk("mrst_busy", 32'(o_busy), 32'd0);
        chk("mrst_cpu_rstn", 32'(o_cpu_rstn), 32'd1);
        chk("mrst_ready", 32'(o_ready), 32'd0);
        chk("mrst_we", 32'(o_we), 32'd0);
        chk("mrst_addr", o_addr, 32'd0);
        chk("mrst_wdata", o_wdata, 32'd0);
        chk("mrst_csum", o_csum, 32'd0);
        run_normal(1'b0, "after_rst");

        chk("byte_timeouts", 32'(n_tmo), 32'd0);
        chk("final_no_we_with_ready", 32'(overlap_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
